// File: rtl/regfile_mp.sv
// Multi-port GPR file: NUM_RD combinational read ports, NUM_WR synchronous
// write ports, a per-register busy scoreboard, and a sweep-clear sequence
// after reset that zeroes every register one per cycle.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   CLEAR | sweeping regs[cnt] <= 0; writes/alloc ignored; reads gated to 0
//   READY | file usable; only cpu_rst leaves this state
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 1,
  parameter int R0_ZERO = 1
) (
  input  logic                       cpu_clk_50M,
  input  logic                       cpu_rst,
  output logic                       ready,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       alloc_en,
  input  logic [ADDR_W-1:0]          alloc_addr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]    busy;

  // A write or alloc targeting r0 is dropped when r0 is hardwired to zero.
  function automatic logic is_r0(input logic [ADDR_W-1:0] a);
    return (R0_ZERO != 0) && (a == '0);
  endfunction

  // State register and sweep counter; reset restarts the sweep at 0.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) cnt <= cnt + ADDR_W'(1);
    end
  end

  // Next state: leave CLEAR after the last register has been zeroed.
  always_comb begin
    state_nxt = state;
    ready     = (state == READY);
    if (state == CLEAR && cnt == LAST) state_nxt = READY;
  end

  // Register array: sweep clear in CLEAR, port writes in READY (highest port wins).
  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst) begin
      if (state == CLEAR) begin
        regs[cnt] <= '0;
      end else begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && !is_r0(wr_addr[j*ADDR_W +: ADDR_W]))
            regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Scoreboard: writes clear busy, then alloc sets it so alloc wins a same-cycle tie.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      busy <= '0;
    end else if (state == READY) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j]) busy[wr_addr[j*ADDR_W +: ADDR_W]] <= 1'b0;
      end
      if (alloc_en && !is_r0(alloc_addr)) busy[alloc_addr] <= 1'b1;
    end
  end

  // Combinational read ports with enable, r0 and CLEAR gating.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i*DATA_W +: DATA_W] = regs[rd_addr[i*ADDR_W +: ADDR_W]];
      rd_busy[i]                  = busy[rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      // Forward the winning same-cycle write; busy shows its post-edge value.
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W]) begin
          rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
          rd_busy[i] = alloc_en && (alloc_addr == rd_addr[i*ADDR_W +: ADDR_W]);
        end
      end
`else
`endif
      if (state != READY || !rd_en[i] || is_r0(rd_addr[i*ADDR_W +: ADDR_W])) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
        rd_busy[i]                  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (two read ports, two write ports).
module tb_regfile_mp;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst;
  logic        ready;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;

  int n_cmp = 0;
  int n_err = 0;
  int n_low;

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .R0_ZERO(1)) dut (
    .cpu_clk_50M(cpu_clk_50M),
    .cpu_rst(cpu_rst),
    .ready(ready),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_busy(rd_busy),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .alloc_en(alloc_en),
    .alloc_addr(alloc_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      n++;
      tick();
    end
  endtask

  initial begin
    cpu_rst = 1'b1; rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0;
    wr_data = '0; alloc_en = 1'b0; alloc_addr = '0;

    // Reset state
    tick();
    rd_en = 2'b11; rd_addr = {5'd31, 5'd2};
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rd0", rd_data[31:0], 32'd0);
    chk("rst_busy", {30'd0, rd_busy}, 32'd0);

    // Release; write r2 and alloc r4 throughout the sweep (must be ignored)
    cpu_rst = 1'b0;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd2}; wr_data = {32'd0, 32'hFFFF_FFFF};
    alloc_en = 1'b1; alloc_addr = 5'd4;
    #1;
    chk("sweep_rd_gated", rd_data[63:32], 32'd0);
    wait_ready(n_low);
    chk("sweep_low_cycles", 32'(n_low), 32'd32);
    chk("ready_high", {31'd0, ready}, 32'd1);
    wr_en = '0; alloc_en = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      chk("init_p0", rd_data[31:0], 32'd0);
      chk("init_p1", rd_data[63:32], 32'd0);
    end
    rd_addr = {5'd0, 5'd4};
    #1;
    chk("sweep_alloc_ignored", {31'd0, rd_busy[0]}, 32'd0);

    // r5 write, read next cycle on both ports, then with rd_en low
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'hDEAD_BEEF};
    tick();
    wr_en = '0; rd_addr = {5'd5, 5'd5};
    #1;
    chk("r5_p0", rd_data[31:0], 32'hDEAD_BEEF);
    chk("r5_p1", rd_data[63:32], 32'hDEAD_BEEF);
    rd_en = 2'b00;
    #1;
    chk("r5_p0_disabled", rd_data[31:0], 32'd0);
    chk("r5_p1_disabled", rd_data[63:32], 32'd0);
    rd_en = 2'b11;

    // r0 hardwired: write and alloc ignored
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'd0, 32'h1234};
    tick();
    wr_en = '0; alloc_en = 1'b1; alloc_addr = 5'd0;
    tick();
    alloc_en = 1'b0; rd_addr = {5'd0, 5'd0};
    #1;
    chk("r0_data", rd_data[31:0], 32'd0);
    chk("r0_busy", {31'd0, rd_busy[0]}, 32'd0);

    // Two ports write r7 in the same cycle: port 1 wins
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
    tick();
    wr_en = '0; rd_addr = {5'd7, 5'd7};
    #1;
    chk("r7_port_prio", rd_data[31:0], 32'h22);

    // Scoreboard on r9
    alloc_en = 1'b1; alloc_addr = 5'd9;
    tick();
    alloc_en = 1'b0; rd_addr = {5'd9, 5'd9};
    #1;
    chk("r9_alloc_busy", {31'd0, rd_busy[0]}, 32'd1);
    chk("r9_alloc_busy_p1", {31'd0, rd_busy[1]}, 32'd1);
    alloc_en = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'd0, 32'h55};
    tick();
    alloc_en = 1'b0; wr_en = '0;
    #1;
    chk("r9_alloc_wr_busy", {31'd0, rd_busy[0]}, 32'd1);
    chk("r9_alloc_wr_data", rd_data[31:0], 32'h55);
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h77, 32'd0};
    tick();
    wr_en = '0;
    #1;
    chk("r9_wr_clears_busy", {31'd0, rd_busy[0]}, 32'd0);
    chk("r9_wr_data", rd_data[31:0], 32'h77);

    // Same-cycle write and read of r3 (busy beforehand)
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'h5A};
    alloc_en = 1'b1; alloc_addr = 5'd3;
    tick();
    wr_en = '0; alloc_en = 1'b0; rd_addr = {5'd3, 5'd3};
    #1;
    chk("r3_pre", rd_data[31:0], 32'h5A);
    wr_en = 2'b01; wr_data = {32'd0, 32'hA5};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("r3_same_cycle_data", rd_data[31:0], 32'hA5);
    chk("r3_same_cycle_busy", {31'd0, rd_busy[0]}, 32'd0);
`else
    chk("r3_same_cycle_data", rd_data[31:0], 32'h5A);
    chk("r3_same_cycle_busy", {31'd0, rd_busy[0]}, 32'd1);
`endif
    tick();
    wr_en = '0;
    #1;
    chk("r3_next_data", rd_data[31:0], 32'hA5);
    chk("r3_next_busy", {31'd0, rd_busy[0]}, 32'd0);

    // Reset mid-sweep at cnt=10 restarts the full sweep
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    repeat (10) tick();
    chk("midsweep_ready", {31'd0, ready}, 32'd0);
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    wait_ready(n_low);
    chk("restart_low_cycles", 32'(n_low), 32'd32);
    rd_addr = {5'd3, 5'd5};
    #1;
    chk("restart_r5_cleared", rd_data[31:0], 32'd0);
    chk("restart_r3_cleared", rd_data[63:32], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
